// File: rtl/mem_resp_types.sv
// rtl/mem_resp_types.sv - shared types for the memory responder
package mem_resp_types;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      RESPOND = 2'd2
   } mem_resp_state_t;

   typedef enum logic {
      PORT_INST = 1'b0,
      PORT_DATA = 1'b1
   } mem_port_t;

   // Latency counter width; holds LATENCY-2 for LATENCY up to 15
   localparam int CNT_W = 4;

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - single-port word array with byte write enables
module mem_array #(
   parameter int DEPTH = 16384,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          en,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem_q [DEPTH];
   logic [31:0] rdata_q;

   // One access per enabled edge: byte-masked write, or registered read
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int i = 0; i < 4; i++) begin
               if (be[i]) begin
                  mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
               end
            end
         end else begin
            rdata_q <= mem_q[addr];
         end
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - fixed-latency inst/data responder over a shared array
module mem_responder
   import mem_resp_types::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int LATENCY    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_read,
   input  logic [31:0] inst_addr,
   output logic [31:0] inst_rdata,
   output logic        inst_resp,
   input  logic        data_read,
   input  logic        data_write,
   input  logic [3:0]  data_mbe,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic [31:0] data_rdata,
   output logic        data_resp,
   output logic        proto_err
);

   localparam int IDX_W = ADDR_WIDTH - 2;
   localparam int DEPTH = 1 << IDX_W;
   localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

   mem_resp_state_t   state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   mem_port_t         port_q, port_d;
   logic              wr_q, wr_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [3:0]        mbe_q, mbe_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              proto_err_q, proto_err_d;
   logic [31:0]       inst_rdata_q, inst_rdata_d;
   logic [31:0]       data_rdata_q, data_rdata_d;

   logic        data_req;
   logic        accept_data;
   logic        accept_inst;
   logic        mem_en;
   logic [31:0] mem_rdata;

   // Address bits outside the decoded word index are deliberately dropped
   logic unused_addr_bits;
   assign unused_addr_bits = ^{inst_addr[31:ADDR_WIDTH], inst_addr[1:0],
                               data_addr[31:ADDR_WIDTH], data_addr[1:0]};

   assign data_req    = data_read | data_write;
   assign accept_data = (state_q == IDLE) && data_req;
   assign accept_inst = (state_q == IDLE) && !data_req && inst_read;

   // State, counter, capture and output holding registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         port_q       <= PORT_INST;
         wr_q         <= 1'b0;
         idx_q        <= '0;
         mbe_q        <= '0;
         wdata_q      <= '0;
         proto_err_q  <= 1'b0;
         inst_rdata_q <= '0;
         data_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         port_q       <= port_d;
         wr_q         <= wr_d;
         idx_q        <= idx_d;
         mbe_q        <= mbe_d;
         wdata_q      <= wdata_d;
         proto_err_q  <= proto_err_d;
         inst_rdata_q <= inst_rdata_d;
         data_rdata_q <= data_rdata_d;
      end
   end

   // Next state: data port wins arbitration, then count down the latency
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (accept_data || accept_inst) begin
               if (LATENCY == 1) begin
                  state_d = RESPOND;
               end else begin
                  state_d = ACCESS;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         ACCESS: begin
            if (cnt_q == '0) begin
               state_d = RESPOND;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESPOND: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Request capture on acceptance; read+write together is a write plus sticky error
   always_comb begin
      port_d      = port_q;
      wr_d        = wr_q;
      idx_d       = idx_q;
      mbe_d       = mbe_q;
      wdata_d     = wdata_q;
      proto_err_d = proto_err_q;
      if (accept_data) begin
         port_d      = PORT_DATA;
         wr_d        = data_write;
         idx_d       = data_addr[ADDR_WIDTH-1:2];
         mbe_d       = data_mbe;
         wdata_d     = data_wdata;
         proto_err_d = proto_err_q | (data_read & data_write);
      end else if (accept_inst) begin
         port_d = PORT_INST;
         wr_d   = 1'b0;
         idx_d  = inst_addr[ADDR_WIDTH-1:2];
         mbe_d  = '0;
      end
   end

   // Array is touched only on the edge entering RESPOND; the *_d capture values
   // equal the live request when LATENCY is 1 and the held request otherwise
   assign mem_en = rst && (((state_q == ACCESS) && (cnt_q == '0)) ||
                           ((LATENCY == 1) && (accept_data || accept_inst)));

   mem_array #(
      .DEPTH (DEPTH)
   ) u_mem_array (
      .clk   (clk),
      .en    (mem_en),
      .we    (wr_d),
      .be    (mbe_d),
      .addr  (idx_d),
      .wdata (wdata_d),
      .rdata (mem_rdata)
   );

   // Outputs: pulse the selected port in RESPOND and present/hold its read data
   always_comb begin
      inst_resp    = (state_q == RESPOND) && (port_q == PORT_INST);
      data_resp    = (state_q == RESPOND) && (port_q == PORT_DATA);
      inst_rdata   = inst_resp ? mem_rdata : inst_rdata_q;
      data_rdata   = (data_resp && !wr_q) ? mem_rdata : data_rdata_q;
      inst_rdata_d = inst_rdata;
      data_rdata_d = data_rdata;
      proto_err    = proto_err_q;
   end

endmodule
